// File: rtl/rv_sequencer.sv
// rv_sequencer: multi-cycle fetch / decode / execute / memory / writeback sequencer.
// Build macro RV_SEQUENCER_SINGLE_STEP_EN adds a step input that gates every fetch.
module rv_sequencer #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}},
   parameter logic [XLEN-1:0] MMIO_BASE = XLEN'(32'h0002_0000),
   parameter int              TIMEOUT   = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ready,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            dec_error,
   input  logic            is_halt,
   input  logic            is_load,
   input  logic            is_store,
   input  logic            jump,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] target,
   input  logic [XLEN-1:0] ea,
`ifdef RV_SEQUENCER_SINGLE_STEP_EN
   input  logic            step,
`endif
   output logic [XLEN-1:0] ir,
   output logic [XLEN-1:0] pc,
   output logic            exec_stb,
   output logic            reg_we,
   output logic            mmio_we,
   output logic [3:0]      state,
   output logic [1:0]      trap_cause
);

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_FETCH      = 4'd1;
   localparam logic [3:0] S_WAIT_FETCH = 4'd2;
   localparam logic [3:0] S_DECODE     = 4'd3;
   localparam logic [3:0] S_EXECUTE    = 4'd4;
   localparam logic [3:0] S_MEM        = 4'd5;
   localparam logic [3:0] S_WAIT_MEM   = 4'd6;
   localparam logic [3:0] S_WB         = 4'd7;
   localparam logic [3:0] S_HALT       = 4'd8;
   localparam logic [3:0] S_TRAP       = 4'd9;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_DECODE  = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
   localparam logic [1:0] CAUSE_ALIGN   = 2'd3;

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [3:0]      state_r;
   logic [3:0]      state_nxt_s;
   logic [1:0]      trap_cause_r;
   logic [1:0]      cause_nxt_s;
   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] ir_r;
   logic            mem_req_r;
   logic            mem_we_r;
   logic [XLEN-1:0] mem_addr_r;
   logic            exec_stb_r;
   logic            reg_we_r;
   logic            mmio_we_r;
   logic [CNT_W-1:0] wait_cnt_r;

   logic mmio_store_s;
   logic mem_access_s;
   logic misaligned_s;
   logic wait_expired_s;
   logic fetch_go_s;
   logic waiting_s;
   logic waiting_nxt_s;
   logic issue_fetch_s;
   logic issue_mem_s;

   // Stores at or above MMIO_BASE bypass the memory port entirely
   assign mmio_store_s   = is_store && (ea >= MMIO_BASE);
   assign mem_access_s   = is_load || (is_store && !mmio_store_s);
   assign misaligned_s   = (pc_r[1:0] != 2'b00);
   assign wait_expired_s = (wait_cnt_r == CNT_W'(TIMEOUT - 1));
`ifdef RV_SEQUENCER_SINGLE_STEP_EN
   assign fetch_go_s     = step;
`else
   assign fetch_go_s     = 1'b1;
`endif
   assign waiting_s      = (state_r == S_WAIT_FETCH) || (state_r == S_WAIT_MEM);
   assign waiting_nxt_s  = (state_nxt_s == S_WAIT_FETCH) || (state_nxt_s == S_WAIT_MEM);
   assign issue_fetch_s  = (state_r == S_FETCH) && (state_nxt_s == S_WAIT_FETCH);
   assign issue_mem_s    = (state_r == S_MEM);

   // Next-state and trap-cause selection
   always_comb begin
      state_nxt_s = state_r;
      cause_nxt_s = CAUSE_NONE;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_nxt_s = S_FETCH;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_FETCH: begin
            if (!fetch_go_s) begin
               state_nxt_s = S_FETCH;
            end else if (misaligned_s) begin
               state_nxt_s = S_TRAP;
               cause_nxt_s = CAUSE_ALIGN;
            end else begin
               state_nxt_s = S_WAIT_FETCH;
            end
         end
         S_WAIT_FETCH: begin
            if (mem_ready) begin
               state_nxt_s = S_DECODE;
            end else if (wait_expired_s) begin
               state_nxt_s = S_TRAP;
               cause_nxt_s = CAUSE_TIMEOUT;
            end else begin
               state_nxt_s = S_WAIT_FETCH;
            end
         end
         S_DECODE: begin
            state_nxt_s = S_EXECUTE;
         end
         S_EXECUTE: begin
            if (is_halt) begin
               state_nxt_s = S_HALT;
            end else if (dec_error) begin
               state_nxt_s = S_TRAP;
               cause_nxt_s = CAUSE_DECODE;
            end else if (mem_access_s) begin
               state_nxt_s = S_MEM;
            end else begin
               state_nxt_s = S_WB;
            end
         end
         S_MEM: begin
            state_nxt_s = S_WAIT_MEM;
         end
         S_WAIT_MEM: begin
            if (mem_ready) begin
               state_nxt_s = S_WB;
            end else if (wait_expired_s) begin
               state_nxt_s = S_TRAP;
               cause_nxt_s = CAUSE_TIMEOUT;
            end else begin
               state_nxt_s = S_WAIT_MEM;
            end
         end
         S_WB: begin
            state_nxt_s = S_FETCH;
         end
         S_HALT: begin
            state_nxt_s = S_HALT;
         end
         S_TRAP: begin
            state_nxt_s = S_TRAP;
            cause_nxt_s = trap_cause_r;
         end
         default: begin
            state_nxt_s = S_IDLE;
            cause_nxt_s = CAUSE_NONE;
         end
      endcase
   end

   // State, strobes and trap cause; strobes are set on entry so they are high for exactly that state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= S_IDLE;
         trap_cause_r <= CAUSE_NONE;
         exec_stb_r   <= 1'b0;
         reg_we_r     <= 1'b0;
         mmio_we_r    <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         trap_cause_r <= cause_nxt_s;
         exec_stb_r   <= (state_nxt_s == S_EXECUTE);
         reg_we_r     <= (state_nxt_s == S_WB) && !is_store;
         mmio_we_r    <= (state_nxt_s == S_WB) && mmio_store_s;
      end
   end

   // Memory request port and per-request wait counter
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req_r  <= 1'b0;
         mem_we_r   <= 1'b0;
         mem_addr_r <= {XLEN{1'b0}};
         wait_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (issue_fetch_s) begin
            mem_req_r  <= 1'b1;
            mem_we_r   <= 1'b0;
            mem_addr_r <= pc_r;
         end else if (issue_mem_s) begin
            mem_req_r  <= 1'b1;
            mem_we_r   <= is_store;
            mem_addr_r <= ea;
         end else if (!waiting_nxt_s) begin
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
         end
         if (waiting_s && waiting_nxt_s) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
         end else begin
            wait_cnt_r <= {CNT_W{1'b0}};
         end
      end
   end

   // Instruction register and program counter
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r <= RESET_PC;
         ir_r <= {XLEN{1'b0}};
      end else begin
         if ((state_r == S_WAIT_FETCH) && mem_ready) begin
            ir_r <= mem_rdata;
         end
         if (state_r == S_WB) begin
            pc_r <= (jump || branch_taken) ? target : (pc_r + XLEN'(32'd4));
         end
      end
   end

   assign state      = state_r;
   assign trap_cause = trap_cause_r;
   assign pc         = pc_r;
   assign ir         = ir_r;
   assign mem_req    = mem_req_r;
   assign mem_we     = mem_we_r;
   assign mem_addr   = mem_addr_r;
   assign exec_stb   = exec_stb_r;
   assign reg_we     = reg_we_r;
   assign mmio_we    = mmio_we_r;

endmodule

// File: tb/tb_rv_sequencer.sv
// Self-checking bench for rv_sequencer: per-instruction expected timelines built from the
// state sequence rules, directed corner cases and a randomized instruction stream.
module tb_rv_sequencer;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] MMIO_BASE = 32'h0002_0000;
   localparam int          TIMEOUT   = 16;

   localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_WAIT_FETCH = 4'd2, S_DECODE = 4'd3;
   localparam logic [3:0] S_EXECUTE = 4'd4, S_MEM = 4'd5, S_WAIT_MEM = 4'd6, S_WB = 4'd7;
   localparam logic [3:0] S_HALT = 4'd8, S_TRAP = 4'd9;

   localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_JUMP = 3, K_BRANCH = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        dec_error;
   logic        is_halt;
   logic        is_load;
   logic        is_store;
   logic        jump;
   logic        branch_taken;
   logic [31:0] target;
   logic [31:0] ea;
   logic        step;
   logic [31:0] ir;
   logic [31:0] pc;
   logic        exec_stb;
   logic        reg_we;
   logic        mmio_we;
   logic [3:0]  state;
   logic [1:0]  trap_cause;

   int checks;
   int errors;
   logic [31:0] mpc;

   typedef struct {
      logic [3:0]  st;
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic        exec;
      logic        rwe;
      logic        mwe;
      logic        rdy;
   } exp_t;

   exp_t tr[$];

   rv_sequencer #(
      .XLEN(32), .RESET_PC(RESET_PC), .MMIO_BASE(MMIO_BASE), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .dec_error(dec_error), .is_halt(is_halt), .is_load(is_load), .is_store(is_store),
      .jump(jump), .branch_taken(branch_taken), .target(target), .ea(ea),
`ifdef RV_SEQUENCER_SINGLE_STEP_EN
      .step(step),
`endif
      .ir(ir), .pc(pc), .exec_stb(exec_stb), .reg_we(reg_we), .mmio_we(mmio_we),
      .state(state), .trap_cause(trap_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      start = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0; dec_error = 1'b0; is_halt = 1'b0;
      is_load = 1'b0; is_store = 1'b0; jump = 1'b0; branch_taken = 1'b0;
      target = 32'h0; ea = 32'h0; step = 1'b1;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      mpc = RESET_PC;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (state !== S_FETCH) begin
         errors++;
         $display("FAIL start: state=%0d expected=%0d", state, S_FETCH);
      end
   endtask

   // Runs one instruction from its FETCH cycle to the next FETCH, checking every cycle
   task automatic exec_instr(input int kind, input logic [31:0] word, input logic [31:0] ea_v,
                             input logic [31:0] tgt_v, input int lf, input int ld);
      logic st_v, mmio_v, memop_v;
      st_v    = (kind == K_STORE);
      mmio_v  = st_v && (ea_v >= MMIO_BASE);
      memop_v = (kind == K_LOAD) || (st_v && !mmio_v);
      is_load = (kind == K_LOAD); is_store = st_v; jump = (kind == K_JUMP);
      branch_taken = (kind == K_BRANCH); target = tgt_v; ea = ea_v; mem_rdata = word;
      is_halt = 1'b0; dec_error = 1'b0;
      tr.delete();
      tr.push_back('{S_FETCH, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
      for (int i = 0; i <= lf; i++)
         tr.push_back('{S_WAIT_FETCH, 1'b1, 1'b0, mpc, 1'b0, 1'b0, 1'b0, (i == lf)});
      tr.push_back('{S_DECODE, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
      tr.push_back('{S_EXECUTE, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
      if (memop_v) begin
         tr.push_back('{S_MEM, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
         for (int i = 0; i <= ld; i++)
            tr.push_back('{S_WAIT_MEM, 1'b1, st_v, ea_v, 1'b0, 1'b0, 1'b0, (i == ld)});
      end
      tr.push_back('{S_WB, 1'b0, 1'b0, 32'h0, 1'b0, !st_v, mmio_v, 1'b0});
      foreach (tr[i]) begin
         checks++;
         if (state !== tr[i].st || mem_req !== tr[i].req || exec_stb !== tr[i].exec ||
             reg_we !== tr[i].rwe || mmio_we !== tr[i].mwe || trap_cause !== 2'd0 ||
             (tr[i].req && (mem_we !== tr[i].we || mem_addr !== tr[i].addr))) begin
            errors++;
            $display("FAIL cycle pc=%h step=%0d: got st=%0d req=%b we=%b addr=%h exec=%b rwe=%b mwe=%b cause=%0d; want st=%0d req=%b we=%b addr=%h exec=%b rwe=%b mwe=%b cause=0",
                     mpc, i, state, mem_req, mem_we, mem_addr, exec_stb, reg_we, mmio_we, trap_cause,
                     tr[i].st, tr[i].req, tr[i].we, tr[i].addr, tr[i].exec, tr[i].rwe, tr[i].mwe);
         end
         mem_ready = tr[i].rdy;
         @(negedge clk);
      end
      mem_ready = 1'b0;
      mpc = (jump || branch_taken) ? tgt_v : mpc + 32'd4;
      checks++;
      if (state !== S_FETCH || pc !== mpc || ir !== word) begin
         errors++;
         $display("FAIL next_pc: st=%0d pc=%h ir=%h expected st=%0d pc=%h ir=%h",
                  state, pc, ir, S_FETCH, mpc, word);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (state !== S_IDLE || pc !== RESET_PC || ir !== 32'h0 || mem_req !== 1'b0 ||
          mem_we !== 1'b0 || mem_addr !== 32'h0 || exec_stb !== 1'b0 || reg_we !== 1'b0 ||
          mmio_we !== 1'b0 || trap_cause !== 2'd0) begin
         errors++;
         $display("FAIL reset: st=%0d pc=%h ir=%h req=%b we=%b addr=%h exec=%b rwe=%b mwe=%b cause=%0d expected all zero",
                  state, pc, ir, mem_req, mem_we, mem_addr, exec_stb, reg_we, mmio_we, trap_cause);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (state !== S_IDLE) begin
         errors++;
         $display("FAIL idle_hold: state=%0d expected=%0d", state, S_IDLE);
      end
   endtask

   task automatic test_alu();
      do_start();
      exec_instr(K_ALU, 32'h0000_0013, 32'h0, 32'h0, 0, 0);
      checks++;
      if (pc !== 32'h4) begin
         errors++;
         $display("FAIL alu_pc: pc=%h expected=%h", pc, 32'h4);
      end
   endtask

   task automatic test_load_store();
      exec_instr(K_LOAD, 32'h0001_2083, 32'h0000_0100, 32'h0, 1, 3);
      exec_instr(K_STORE, 32'h0011_2023, 32'h0002_0010, 32'h0, 0, 0);
      exec_instr(K_STORE, 32'h0011_2223, 32'h0001_FFFC, 32'h0, 2, 1);
      exec_instr(K_BRANCH, 32'h0000_0463, 32'h0, 32'h0000_0400, 0, 0);
   endtask

   task automatic test_random();
      logic [31:0] r;
      int kind;
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 4);
         r = $urandom;
         r[1:0] = 2'b00;
         if (kind == K_STORE) begin
            if ($urandom_range(0, 1) == 0) ea = $urandom_range(0, 32'h1_FFFF);
            else ea = MMIO_BASE + ($urandom & 32'h0FFF_FFFF);
         end else begin
            ea = $urandom;
         end
         exec_instr(kind, $urandom, ea, r, $urandom_range(0, 3), $urandom_range(0, 3));
      end
   endtask

   task automatic test_pc_wrap();
      exec_instr(K_JUMP, 32'h0000_006F, 32'h0, 32'hFFFF_FFFC, 0, 0);
      exec_instr(K_ALU, 32'h0000_0013, 32'h0, 32'h0, 1, 0);
      checks++;
      if (pc !== 32'h0) begin
         errors++;
         $display("FAIL pc_wrap: pc=%h expected=%h", pc, 32'h0);
      end
   endtask

   task automatic test_misaligned();
      exec_instr(K_JUMP, 32'h0000_006F, 32'h0, 32'h0000_0102, 0, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (state !== S_TRAP || trap_cause !== 2'd3 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL misaligned: st=%0d cause=%0d req=%b expected st=%0d cause=3 req=0",
                     state, trap_cause, mem_req, S_TRAP);
         end
      end
   endtask

   task automatic test_timeout();
      apply_reset();
      do_start();
      @(negedge clk);
      for (int i = 0; i < TIMEOUT; i++) begin
         checks++;
         if (state !== S_WAIT_FETCH || mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL timeout_wait %0d: st=%0d req=%b addr=%h expected st=%0d req=1 addr=%h",
                     i, state, mem_req, mem_addr, S_WAIT_FETCH, RESET_PC);
         end
         @(negedge clk);
      end
      checks++;
      if (state !== S_TRAP || trap_cause !== 2'd2 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL timeout_trap: st=%0d cause=%0d req=%b expected st=%0d cause=2 req=0",
                  state, trap_cause, mem_req, S_TRAP);
      end
   endtask

   task automatic run_to_execute(input logic halt_v, input logic err_v);
      apply_reset();
      do_start();
      is_halt = halt_v; dec_error = err_v; is_load = 1'b1; mem_rdata = 32'h0000_0073;
      mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (state !== S_EXECUTE || exec_stb !== 1'b1) begin
         errors++;
         $display("FAIL execute_entry: st=%0d exec=%b expected st=%0d exec=1", state, exec_stb, S_EXECUTE);
      end
   endtask

   task automatic test_dec_error();
      run_to_execute(1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (state !== S_TRAP || trap_cause !== 2'd1 || exec_stb !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL dec_error: st=%0d cause=%0d exec=%b req=%b expected st=%0d cause=1",
                  state, trap_cause, exec_stb, mem_req, S_TRAP);
      end
   endtask

   task automatic test_halt();
      run_to_execute(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (state !== S_HALT || trap_cause !== 2'd0 || exec_stb !== 1'b0 || reg_we !== 1'b0) begin
            errors++;
            $display("FAIL halt: st=%0d cause=%0d exec=%b rwe=%b expected st=%0d cause=0",
                     state, trap_cause, exec_stb, reg_we, S_HALT);
         end
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      do_start();
      exec_instr(K_ALU, 32'h0000_0013, 32'h0, 32'h0, 0, 0);
      is_load = 1'b1; ea = 32'h0000_0300; mem_rdata = 32'h0003_2103;
      mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (state !== S_WAIT_MEM || mem_req !== 1'b1 || mem_addr !== 32'h0000_0300 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL mid_request: st=%0d req=%b addr=%h we=%b expected st=%0d req=1 addr=00000300 we=0",
                  state, mem_req, mem_addr, mem_we, S_WAIT_MEM);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (state !== S_IDLE || pc !== RESET_PC || mem_req !== 1'b0 || ir !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid: st=%0d pc=%h req=%b ir=%h expected st=0 pc=%h req=0 ir=0",
                  state, pc, mem_req, ir, RESET_PC);
      end
      rst = 1'b0;
      is_load = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (state !== S_IDLE || mem_req !== 1'b0 || ir !== 32'h0) begin
         errors++;
         $display("FAIL late_ready: st=%0d req=%b ir=%h expected st=0 req=0 ir=0", state, mem_req, ir);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_alu();
      test_load_store();
      test_random();
      test_pc_wrap();
      test_misaligned();
      test_timeout();
      test_dec_error();
      test_halt();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_sequencer.md
RV_SEQUENCER -- requirements
Module: rv_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and address width.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have parameter MMIO_BASE, default 32'h00020000; store addresses >= MMIO_BASE route to MMIO, not memory.
REQ-004 SHALL have parameter TIMEOUT, default 16, max cycles a memory request may wait for ready.
REQ-005 SHALL have port clk  in  1  single clock; reset is synchronous and active-high (rst), all state changes on rising clk.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port start  in  1  leave IDLE when high.
REQ-008 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out XLEN, mem_ready in 1, mem_rdata in XLEN: memory request handshake.
REQ-009 SHALL have ports dec_error in 1, is_halt in 1, is_load in 1, is_store in 1, jump in 1, branch_taken in 1, target in XLEN, ea in XLEN: decoder/datapath results for current instr.
REQ-010 SHALL have ports ir out XLEN, pc out XLEN, exec_stb out 1, reg_we out 1, mmio_we out 1, state out 4, trap_cause out 2.
REQ-011 SHALL have port step in 1 (present only with SINGLE_STEP_EN).

Function
REQ-012 SHALL implement states IDLE=0, FETCH=1, WAIT_FETCH=2, DECODE=3, EXECUTE=4, MEM=5, WAIT_MEM=6, WB=7, HALT=8, TRAP=9; state output = current encoding.
REQ-013 SHALL transition IDLE->FETCH when start=1, else remain.
REQ-014 SHALL in FETCH: if pc[1:0]!=0 go TRAP with cause 3; else assert mem_req, mem_we=0, mem_addr=pc, go WAIT_FETCH.
REQ-015 SHALL hold mem_req, mem_we, mem_addr stable from request until the cycle mem_ready=1 is sampled; mem_req deasserts the following cycle.
REQ-016 SHALL in WAIT_FETCH on mem_ready=1 latch ir<=mem_rdata and go DECODE; mem_ready in the same cycle as request issue is legal (zero wait).
REQ-017 SHALL count wait cycles per request; reaching TIMEOUT without mem_ready goes TRAP with cause 2, request dropped.
REQ-018 SHALL go DECODE->EXECUTE unconditionally.
REQ-019 SHALL in EXECUTE pulse exec_stb one cycle; priority: is_halt->HALT, dec_error->TRAP cause 1, is_load or (is_store and ea<MMIO_BASE)->MEM, else WB.
REQ-020 SHALL in MEM issue request with mem_addr=ea, mem_we=is_store, go WAIT_MEM; WAIT_MEM follows REQ-015..017, on mem_ready go WB.
REQ-021 SHALL in WB pulse reg_we one cycle unless is_store; pulse mmio_we one cycle when is_store and ea>=MMIO_BASE.
REQ-022 SHALL in WB update pc: target if jump or branch_taken, else pc+4, modulo 2^XLEN (wrap from all-ones-minus-3 to 0); then go FETCH.
REQ-023 SHALL hold HALT and TRAP until rst; trap_cause 0 when not in TRAP.
REQ-024 SHALL keep exec_stb, reg_we, mmio_we low in all states other than those named.

Reset
REQ-025 SHALL on rst=1 set state=IDLE, pc=RESET_PC, ir=0, trap_cause=0, mem_req=0, mem_we=0, mem_addr=0, exec_stb=0, reg_we=0, mmio_we=0, wait counter=0.
REQ-026 SHALL let rst override any state including mid-request; an outstanding request is abandoned and a late mem_ready after reset is ignored in IDLE.

Configuration
REQ-027 SHALL, with macro RV_SEQUENCER_SINGLE_STEP_EN defined, wait in FETCH before issuing each request until step=1 is sampled (one instruction per step pulse, step held high runs freely).
REQ-028 SHALL, without RV_SEQUENCER_SINGLE_STEP_EN, omit port step and issue FETCH requests immediately.

Verification
REQ-029 SHALL verify: rst, start=1, zero-wait memory returns 32'h00000013 (ALU op) -> states 1,2,3,4,7,1; reg_we one pulse; pc 0->4.
REQ-030 SHALL verify: load at ea=0x100 with mem_ready after 3 cycles -> mem_addr=0x100 held 4 cycles, mem_we=0, reg_we in WB.
REQ-031 SHALL verify: store ea=0x00020010 -> no MEM request, mmio_we one pulse in WB, reg_we=0.
REQ-032 SHALL verify: mem_ready never asserted, TIMEOUT=16 -> TRAP 16 cycles after request, trap_cause=2.
REQ-033 SHALL verify: jump with target=0x102 -> next FETCH goes TRAP cause 3; dec_error=1 -> TRAP cause 1; is_halt=1 -> HALT held.
REQ-034 SHALL verify: rst asserted in WAIT_MEM -> next cycle state=0, pc=RESET_PC, mem_req=0; pc wrap 0xFFFFFFFC+4 -> 0.
